// File: rtl/syn_ram_pkg.sv
// Shared definitions for the byte-enable RAM and its clear sequencer.
package syn_ram_pkg;

    // Clear FSM state encoding.
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

endpackage : syn_ram_pkg

// File: rtl/ram_clear_seq.sv
// Clear sequencer: walks every RAM address once, writing the clear word.
module ram_clear_seq
    import syn_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_COUNT = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_req,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] clr_addr,
    output logic                  clr_we
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_COUNT - 1);

    clr_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;

    // Next state and next clear address; clear_req is ignored while clearing.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                end
            end
            CLEAR: begin
                if (clr_addr_q == LAST_ADDR) begin
                    state_d    = IDLE;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                clr_addr_d = '0;
            end
        endcase
    end

    // FSM register; reset always (re)starts a clear from address 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    assign busy     = (state_q == CLEAR);
    assign clr_we   = (state_q == CLEAR);
    assign clr_addr = clr_addr_q;

endmodule : ram_clear_seq

// File: rtl/syn_ram_be.sv
// Single-port-write, registered-read RAM with byte enables and a clear sequencer.
module syn_ram_be
    import syn_ram_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = 16,
    parameter int unsigned           BYTE_WIDTH  = 8,
    parameter int unsigned           ADDR_WIDTH  = 8,
    parameter int unsigned           DATA_COUNT  = 256,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
    localparam int unsigned          BYTES       = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  write_enable,
    input  logic [BYTES-1:0]      byte_en,
    input  logic [ADDR_WIDTH-1:0] addr_out,
    input  logic                  read_enable,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  clear_req,
    output logic                  busy
);

    localparam int unsigned         AW1   = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] DEPTH = AW1'(DATA_COUNT);

    logic [DATA_WIDTH-1:0] mem [DATA_COUNT];

    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  clr_we;
    logic                  user_wr_c;
    logic                  user_rd_c;
    logic                  rd_in_range_c;
    logic [DATA_WIDTH-1:0] rd_word_c;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  data_valid_q, data_valid_d;

    ram_clear_seq #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_COUNT (DATA_COUNT)
    ) u_clear_seq (
        .clk       (clk),
        .rst       (rst),
        .clear_req (clear_req),
        .busy      (busy),
        .clr_addr  (clr_addr),
        .clr_we    (clr_we)
    );

    // User port qualification: the sequencer owns the RAM while busy.
    always_comb begin
        user_wr_c     = !busy && write_enable && ({1'b0, addr_in} < DEPTH);
        user_rd_c     = !busy && read_enable;
        rd_in_range_c = {1'b0, addr_out} < DEPTH;
    end

    // Storage write port; contents are only initialised by the clear sequence.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= CLEAR_VALUE;
        end else if (user_wr_c) begin
            for (int i = 0; i < int'(BYTES); i++) begin
                if (byte_en[i]) begin
                    mem[addr_in][i*BYTE_WIDTH +: BYTE_WIDTH] <= data_in[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Read word with write-first bypass of enabled lanes on an address hit.
    always_comb begin
        rd_word_c = '0;
        if (rd_in_range_c) begin
            rd_word_c = mem[addr_out];
            if (user_wr_c && (addr_in == addr_out)) begin
                for (int i = 0; i < int'(BYTES); i++) begin
                    if (byte_en[i]) begin
                        rd_word_c[i*BYTE_WIDTH +: BYTE_WIDTH] = data_in[i*BYTE_WIDTH +: BYTE_WIDTH];
                    end
                end
            end
        end
    end

    // Next read-port state: load on a read, otherwise hold data and drop valid.
    always_comb begin
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        if (user_rd_c) begin
            data_out_d   = rd_word_c;
            data_valid_d = 1'b1;
        end
    end

    // Read-port registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;

endmodule : syn_ram_be

// File: doc/syn_ram_be.md
SYN_RAM_BE -- requirements
Module: syn_ram_be

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the word width in bits; it must be a multiple of BYTE_WIDTH.
REQ-002 Parameter BYTE_WIDTH, default 8, SHALL set the byte-lane width; BYTES = DATA_WIDTH/BYTE_WIDTH.
REQ-003 Parameter ADDR_WIDTH, default 8, SHALL set the width of both address ports.
REQ-004 Parameter DATA_COUNT, default 256, SHALL set the number of words and be at most 2^ADDR_WIDTH.
REQ-005 Parameter CLEAR_VALUE, default 0, DATA_WIDTH bits, SHALL be the word written by the clear sequencer.
REQ-006 clk  input  1  The single clock; all state SHALL change on its rising edge.
REQ-007 rst  input  1  Reset, synchronous and active-high.
REQ-008 addr_in  input  ADDR_WIDTH  Write address.
REQ-009 data_in  input  DATA_WIDTH  Write data.
REQ-010 write_enable  input  1  Write strobe.
REQ-011 byte_en  input  BYTES  Per-lane write mask; bit i covers data bits [i*BYTE_WIDTH +: BYTE_WIDTH].
REQ-012 addr_out  input  ADDR_WIDTH  Read address.
REQ-013 read_enable  input  1  Read strobe.
REQ-014 data_out  output  DATA_WIDTH  Registered read data.
REQ-015 data_valid  output  1  One-cycle pulse qualifying data_out.
REQ-016 clear_req  input  1  Request to fill the whole memory with CLEAR_VALUE.
REQ-017 busy  output  1  High while the clear sequencer owns the write port.

Function
REQ-018 The FSM SHALL have two states: CLEAR and IDLE.
REQ-019 In CLEAR, the block SHALL write CLEAR_VALUE to address clr_addr each cycle, starting at 0 and incrementing by 1.
REQ-020 After writing DATA_COUNT-1, the FSM SHALL enter IDLE on the next edge; a clear SHALL take exactly DATA_COUNT cycles.
REQ-021 busy SHALL equal (state == CLEAR), so it is registered and glitch-free.
REQ-022 In IDLE, clear_req=1 SHALL move the FSM to CLEAR with clr_addr=0 on the next edge.
REQ-023 In CLEAR, clear_req SHALL be ignored and SHALL NOT restart the sequence.
REQ-024 In CLEAR, user writes SHALL be dropped, and the same applies to user reads: no data_valid pulse is produced.
REQ-025 In IDLE, with write_enable=1 and addr_in < DATA_COUNT, each lane with byte_en[i]=1 SHALL be updated and all other lanes SHALL keep their values.
REQ-026 A write with addr_in >= DATA_COUNT SHALL be ignored.
REQ-027 In IDLE, read_enable=1 SHALL load data_out with the word at addr_out on the next edge and pulse data_valid high for one cycle, giving a latency of 1.
REQ-028 A read with addr_out >= DATA_COUNT SHALL return all zeros with data_valid=1.
REQ-029 On a same-cycle read and write to the same address, data_out SHALL return the merged new word (write-first), per lane according to byte_en.
REQ-030 When no read occurs, data_out SHALL hold its last value and data_valid SHALL be 0.
REQ-031 Back-to-back reads SHALL be supported at one per cycle with no bubbles.

Reset
REQ-032 While rst=1 at an edge, data_out SHALL be set to 0 and data_valid to 0.
REQ-033 While rst=1 at an edge, the state SHALL be set to CLEAR and clr_addr to 0, so busy=1 from the first edge after rst rises.
REQ-034 A reset during a clear SHALL restart the clear from address 0.
REQ-035 Memory contents SHALL NOT be reset directly; they are initialised only by the clear sequence that follows reset.

Structure
REQ-036 The FSM state encodings (CLEAR=1'b1, IDLE=1'b0) SHALL live in a shared package/include, syn_ram_pkg.
REQ-037 The clear FSM and address counter SHALL be a sub-module, ram_clear_seq, with outputs busy, clr_addr and clr_we.
REQ-038 Storage SHALL be a single array of DATA_COUNT words with one write port and one registered read port, so it infers block RAM.

Verification (DATA_WIDTH=16, DATA_COUNT=256)
REQ-039 Release rst, wait for busy to fall, then read addresses 0, 128 and 255 -> busy stays high for exactly 256 cycles; each read returns 0x0000 with data_valid one cycle after read_enable.
REQ-040 Write 0xABCD to address 5 with byte_en=2'b11, then write 0x1234 with byte_en=2'b01, then read address 5 -> 0xAB34.
REQ-041 In one cycle, write 0x5A5A to address 9 and read address 9 -> data_out=0x5A5A on the next cycle (write-first).
REQ-042 Assert clear_req, attempt a write of 0xFFFF to address 3 on cycle 10 of the clear, then read after busy falls -> 0x0000, with no data_valid during busy.
REQ-043 Assert rst at clear cycle 100, release it, then count cycles -> busy stays high for a further 256 cycles.
REQ-044 Issue reads to addresses 0..3 on four consecutive cycles after writing 0x0001..0x0004 -> four consecutive data_valid pulses carrying 0x0001..0x0004 in order.
